mbc1_cart_responder: RTL and testbench

Cartridge-side responder for the console cartridge bus. It is the far end of the console's cartridge bus master and lets a ROM/RAM image in FPGA block RAM stand in for a physical MBC1 cartridge. It synchronises the asynchronous bus strobes, decodes MBC1 register writes, and maps console addresses to banked ROM/RAM addresses. It serves reads by driving data back onto the bus, and commits writes to external cartridge RAM.

---
 rtl/mbc1_cart_responder.sv | 163 ++++++++++++++++
 tb/tb_mbc1_cart_responder.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/mbc1_cart_responder.sv
// mbc1_cart_responder: MBC1 cartridge emulation on the console bus, backed by block-RAM ROM/RAM images.
// Define MBC1_MULTICART_EN for MBC1M wiring (4-bit bank_lo contribution).
module mbc1_cart_responder #(
    parameter int ROM_ADDR_W = 21,
    parameter int RAM_ADDR_W = 15,
    parameter int MEM_LAT    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cart_n_rst,
    input  logic                  cart_n_cs,
    input  logic                  cart_n_rd,
    input  logic                  cart_n_wr,
    input  logic [15:0]           cart_addr,
    input  logic [7:0]            cart_data_in,
    output logic [7:0]            cart_data_out,
    output logic                  cart_data_oe,
    output logic [ROM_ADDR_W-1:0] rom_addr,
    output logic                  rom_rd,
    input  logic [7:0]            rom_rdata,
    output logic [RAM_ADDR_W-1:0] ram_addr,
    output logic                  ram_rd,
    output logic                  ram_we,
    output logic [7:0]            ram_wdata,
    input  logic [7:0]            ram_rdata,
    output logic [6:0]            rom_bank,
    output logic                  ram_enabled
);
    typedef enum logic [1:0] {IDLE, WAIT, DRIVE} state_t;
    state_t state, state_nx;
    logic [1:0]  nrst_sr, cs_sr;
    logic [2:0]  rd_sr, wr_sr;
    logic [15:0] a1, a2;
    logic [7:0]  d1, d2;
    logic        ram_en, mode, sel_ram;
    logic [4:0]  bank_lo;
    logic [1:0]  bank_hi;
    logic [2:0]  cnt;
    logic [6:0]  hi_bank, lo_bank;
    logic [20:0] rom_full;
    logic [14:0] ram_full;
    logic        bus_on, rd_fall, wr_fall, rd_go, rom_hit, ram_hit, lat_done;

    // Strobes get a history flop for edge detect; addr/data only need two sync stages
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nrst_sr <= 2'b11;
            cs_sr   <= 2'b11;
            rd_sr   <= 3'b111;
            wr_sr   <= 3'b111;
            a1      <= '0;
            a2      <= '0;
            d1      <= '0;
            d2      <= '0;
        end else begin
            nrst_sr <= {nrst_sr[0], cart_n_rst};
            cs_sr   <= {cs_sr[0], cart_n_cs};
            rd_sr   <= {rd_sr[1:0], cart_n_rd};
            wr_sr   <= {wr_sr[1:0], cart_n_wr};
            a1      <= cart_addr;
            a2      <= a1;
            d1      <= cart_data_in;
            d2      <= d1;
        end
    end

    assign bus_on   = nrst_sr[1];
    assign rd_fall  = bus_on & rd_sr[2] & ~rd_sr[1];
    assign wr_fall  = bus_on & wr_sr[2] & ~wr_sr[1];
    assign rd_go    = rd_fall & ~wr_fall & (state == IDLE);
    assign rom_hit  = ~a2[15];
    assign ram_hit  = (a2[15:13] == 3'b101) & ~cs_sr[1] & ram_en;
    assign lat_done = (state == WAIT) & (cnt == 3'(MEM_LAT)) & ~rd_sr[1];

`ifdef MBC1_MULTICART_EN
    assign hi_bank = {1'b0, bank_hi, bank_lo[3:0]};
    assign lo_bank = mode ? {1'b0, bank_hi, 4'b0} : 7'd0;
`else
    assign hi_bank = {bank_hi, bank_lo};
    assign lo_bank = mode ? {bank_hi, 5'b0} : 7'd0;
`endif

    assign rom_full    = {a2[14] ? hi_bank : lo_bank, a2[13:0]};
    assign ram_full    = {mode ? bank_hi : 2'b0, a2[12:0]};
    assign rom_bank    = hi_bank;
    assign ram_enabled = ram_en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (!bus_on)
            state_nx = IDLE;
        else if (rd_go)
            state_nx = (rom_hit | ram_hit) ? WAIT : DRIVE;
        else if (state == WAIT)
            state_nx = rd_sr[1] ? IDLE : lat_done ? DRIVE : WAIT;
        else if (state == DRIVE && rd_sr[1])
            state_nx = IDLE;
    end

    always_comb begin
        cart_data_oe = (state == DRIVE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cart_data_out <= 8'hFF;
            rom_addr      <= '0;
            rom_rd        <= 1'b0;
            ram_addr      <= '0;
            ram_rd        <= 1'b0;
            ram_we        <= 1'b0;
            ram_wdata     <= '0;
            ram_en        <= 1'b0;
            bank_lo       <= 5'd1;
            bank_hi       <= 2'd0;
            mode          <= 1'b0;
            sel_ram       <= 1'b0;
            cnt           <= '0;
        end else begin
            rom_rd <= 1'b0;
            ram_rd <= 1'b0;
            ram_we <= 1'b0;
            cnt    <= (state == WAIT) ? cnt + 3'd1 : 3'd0;
            if (!bus_on) begin
                ram_en  <= 1'b0;
                bank_lo <= 5'd1;
                bank_hi <= 2'd0;
                mode    <= 1'b0;
            end else begin
                if (wr_fall) begin
                    if (a2[15:13] == 3'b000) ram_en <= (d2[3:0] == 4'hA);
                    if (a2[15:13] == 3'b001) bank_lo <= (d2[4:0] == 5'd0) ? 5'd1 : d2[4:0];
                    if (a2[15:13] == 3'b010) bank_hi <= d2[1:0];
                    if (a2[15:13] == 3'b011) mode <= d2[0];
                    if (ram_hit) begin
                        ram_we    <= 1'b1;
                        ram_addr  <= ram_full[RAM_ADDR_W-1:0];
                        ram_wdata <= d2;
                    end
                end
                if (rd_go) begin
                    if (rom_hit) begin
                        rom_rd   <= 1'b1;
                        rom_addr <= rom_full[ROM_ADDR_W-1:0];
                        sel_ram  <= 1'b0;
                    end else if (ram_hit) begin
                        ram_rd   <= 1'b1;
                        ram_addr <= ram_full[RAM_ADDR_W-1:0];
                        sel_ram  <= 1'b1;
                    end else begin
                        cart_data_out <= 8'hFF;
                    end
                end
                if (lat_done) cart_data_out <= sel_ram ? ram_rdata : rom_rdata;
            end
        end
    end
endmodule

// File: tb/tb_mbc1_cart_responder.sv
// tb_mbc1_cart_responder: directed bus transactions against hand-computed MBC1 mappings.
module tb_mbc1_cart_responder;
    logic        clk = 0, rst = 1;
    logic        cart_n_rst = 1, cart_n_cs = 1, cart_n_rd = 1, cart_n_wr = 1;
    logic [15:0] cart_addr = 0;
    logic [7:0]  cart_data_in = 0, cart_data_out;
    logic        cart_data_oe;
    logic [20:0] rom_addr;
    logic        rom_rd, ram_rd, ram_we;
    logic [7:0]  rom_rdata = 0, ram_rdata = 0, ram_wdata;
    logic [14:0] ram_addr;
    logic [6:0]  rom_bank;
    logic        ram_enabled;
    int          n_checks = 0, n_errors = 0;
    int          rom_rd_cnt = 0, ram_rd_cnt = 0, ram_we_cnt = 0;
    logic [20:0] last_rom_addr = 0;
    logic [14:0] last_ram_addr = 0;
    logic [7:0]  last_wdata = 0, rom_p = 0, ram_p = 0, rd_data;
    logic [7:0]  ram_mem [0:32767];
    int          r0, w0, m0;
    bit          seen;

    mbc1_cart_responder dut (
        .clk(clk), .rst(rst), .cart_n_rst(cart_n_rst), .cart_n_cs(cart_n_cs),
        .cart_n_rd(cart_n_rd), .cart_n_wr(cart_n_wr), .cart_addr(cart_addr),
        .cart_data_in(cart_data_in), .cart_data_out(cart_data_out), .cart_data_oe(cart_data_oe),
        .rom_addr(rom_addr), .rom_rd(rom_rd), .rom_rdata(rom_rdata), .ram_addr(ram_addr),
        .ram_rd(ram_rd), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .rom_bank(rom_bank), .ram_enabled(ram_enabled)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] rom_byte(input logic [20:0] a);
        return (a == 21'h150) ? 8'hC3 : a[7:0] ^ 8'h3C;
    endfunction

    // Two-stage backing memories match MEM_LAT=2
    always @(posedge clk) begin
        if (ram_we) ram_mem[ram_addr] <= ram_wdata;
        rom_p     <= rom_byte(rom_addr);
        rom_rdata <= rom_p;
        ram_p     <= ram_mem[ram_addr];
        ram_rdata <= ram_p;
    end

    always @(negedge clk) begin
        if (rom_rd) begin rom_rd_cnt++; last_rom_addr = rom_addr; end
        if (ram_rd) begin ram_rd_cnt++; last_ram_addr = ram_addr; end
        if (ram_we) begin ram_we_cnt++; last_ram_addr = ram_addr; last_wdata = ram_wdata; end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
        cart_addr = a;
        cart_data_in = d;
        cart_n_cs = (a >= 16'hA000) ? 1'b0 : 1'b1;
        cyc(4);
        cart_n_wr = 0;
        cyc(6);
        cart_n_wr = 1;
        cyc(4);
        cart_n_cs = 1;
    endtask

    task automatic bus_read(input logic [15:0] a, output logic [7:0] d);
        int n;
        cart_addr = a;
        cart_n_cs = (a >= 16'hA000) ? 1'b0 : 1'b1;
        cyc(4);
        cart_n_rd = 0;
        n = 0;
        while (!cart_data_oe && n < 40) begin cyc(1); n++; end
        check("oe_rise", cart_data_oe, 1);
        d = cart_data_out;
        cyc(3);
        check("oe_hold", cart_data_oe, 1);
        cart_n_rd = 1;
        cyc(5);
        check("oe_fall", cart_data_oe, 0);
        cart_n_cs = 1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 32768; i++) ram_mem[i] = 8'h00;
        cyc(3);
        check("rst_oe", cart_data_oe, 0);
        check("rst_dout", cart_data_out, 8'hFF);
        check("rst_bank", rom_bank, 7'd1);
        check("rst_ram_en", ram_enabled, 0);
        check("rst_rom_addr", rom_addr, 0);
        rst = 0;
        cyc(4);

        r0 = rom_rd_cnt;
        bus_read(16'h0150, rd_data);
        check("t1_rom_rd", rom_rd_cnt - r0, 1);
        check("t1_addr", last_rom_addr, 21'h00150);
        check("t1_data", rd_data, 8'hC3);

        bus_write(16'h2000, 8'h00);
        check("t2_bank0as1", rom_bank, 7'd1);
        bus_read(16'h4000, rd_data);
        check("t2_addr4000", last_rom_addr, 21'h04000);
        bus_write(16'h2000, 8'h13);
        bus_write(16'h4000, 8'h02);
`ifdef MBC1_MULTICART_EN
        check("t2_bank53", rom_bank, 7'h23);
        bus_read(16'h7FFF, rd_data);
        check("t2_addr7fff", last_rom_addr, 21'h08FFFF);
`else
        check("t2_bank53", rom_bank, 7'h53);
        bus_read(16'h7FFF, rd_data);
        check("t2_addr7fff", last_rom_addr, 21'h14FFFF);
`endif
        check("t2_data", rd_data, 8'hC3);

        w0 = ram_we_cnt;
        bus_write(16'hA123, 8'h5A);
        check("t3_we_disabled", ram_we_cnt - w0, 0);
        bus_write(16'h0000, 8'h0A);
        check("t3_ram_en", ram_enabled, 1);
        bus_write(16'hA123, 8'h5A);
        check("t3_we_once", ram_we_cnt - w0, 1);
        check("t3_we_addr", last_ram_addr, 15'h0123);
        check("t3_wdata", last_wdata, 8'h5A);
        m0 = ram_rd_cnt;
        bus_read(16'hA123, rd_data);
        check("t3_ram_rd", ram_rd_cnt - m0, 1);
        check("t3_rdata", rd_data, 8'h5A);
        bus_write(16'h0000, 8'h00);
        m0 = ram_rd_cnt;
        bus_read(16'hA123, rd_data);
        check("t3_dis_data", rd_data, 8'hFF);
        check("t3_dis_no_rd", ram_rd_cnt - m0, 0);

        bus_write(16'h6000, 8'h01);
        bus_write(16'h4000, 8'h03);
        bus_write(16'h0000, 8'h0A);
        bus_read(16'h0001, rd_data);
`ifdef MBC1_MULTICART_EN
        check("t4_mode1_rom", last_rom_addr, 21'h0C0001);
`else
        check("t4_mode1_rom", last_rom_addr, 21'h180001);
`endif
        bus_read(16'hB000, rd_data);
        check("t4_mode1_ram", last_ram_addr, 15'h7000);

        r0 = rom_rd_cnt;
        m0 = ram_rd_cnt;
        bus_read(16'hC000, rd_data);
        check("t5_open_data", rd_data, 8'hFF);
        check("t5_no_mem_rd", (rom_rd_cnt - r0) + (ram_rd_cnt - m0), 0);

        cart_addr = 16'h0100;
        cyc(4);
        cart_n_rd = 0;
        r0 = rom_rd_cnt;
        for (int i = 0; i < 20 && !rom_rd; i++) cyc(1);
        cart_n_rd = 1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin cyc(1); if (cart_data_oe) seen = 1; end
        check("t5_abort_oe", seen, 0);
        check("t5_abort_rd", rom_rd_cnt - r0, 1);
        check("t5_abort_dout", cart_data_out, 8'hFF);

        cart_addr = 16'h0150;
        cyc(4);
        cart_n_rd = 0;
        for (int i = 0; i < 40 && !cart_data_oe; i++) cyc(1);
        check("t5_drive_oe", cart_data_oe, 1);
        cart_n_rst = 0;
        cyc(3);
        check("t5_nrst_oe", cart_data_oe, 0);
        check("t5_nrst_bank", rom_bank, 7'd1);
        check("t5_nrst_ram_en", ram_enabled, 0);
        cart_n_rd = 1;
        cart_n_rst = 1;
        cyc(4);

        bus_write(16'h2000, 8'h13);
        bus_write(16'h4000, 8'h01);
        bus_read(16'h4000, rd_data);
`ifdef MBC1_MULTICART_EN
        check("t6_bank", rom_bank, 7'h13);
        check("t6_addr", last_rom_addr, 21'h04C000);
`else
        check("t6_bank", rom_bank, 7'h33);
        check("t6_addr", last_rom_addr, 21'h0CC000);
`endif
        check("t6_data", rd_data, 8'h3C);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
